mips32_mem_responder: RTL and testbench



---
 rtl/mips32_isa_pkg.sv | 27 ++
 rtl/mips32_mem_pkg.sv | 13 +
 rtl/mips32_rr_arbiter.sv | 31 +++
 rtl/mips32_mem_responder.sv | 129 ++++++++++++
 tb/tb_mips32_mem_responder.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips32_isa_pkg.sv
// Opcode and instruction-type encodings shared by the pipe_MIPS32 core and its
// memory-side blocks, so both sides decode LW/SW identically.
package mips32_isa_pkg;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
    localparam logic [5:0] OP_MUL   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd8;
    localparam logic [5:0] OP_SW    = 6'd9;
    localparam logic [5:0] OP_ADDI  = 6'd10;
    localparam logic [5:0] OP_SUBI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_BNEQZ = 6'd13;
    localparam logic [5:0] OP_BEQZ  = 6'd14;
    localparam logic [5:0] OP_HLT   = 6'h3F;

    localparam logic [2:0] TY_RR_ALU = 3'd0;
    localparam logic [2:0] TY_RM_ALU = 3'd1;
    localparam logic [2:0] TY_LOAD   = 3'd2;
    localparam logic [2:0] TY_STORE  = 3'd3;
    localparam logic [2:0] TY_BRANCH = 3'd4;
    localparam logic [2:0] TY_HALT   = 3'd5;

endpackage

// File: rtl/mips32_mem_pkg.sv
// Shared types and defaults for the handshaked instruction/data memory responder.
package mips32_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEPTH_DEF       = 1024;
    localparam int AW_DEF          = 10;
    localparam int WAIT_STATES_DEF = 1;

endpackage

// File: rtl/mips32_rr_arbiter.sv
// Two-requester round-robin arbiter; the pointer flips to the other port after every grant.
module mips32_rr_arbiter
    import mips32_mem_pkg::*;
(
    input  logic clk1,
    input  logic reset,
    input  logic req_fetch,
    input  logic req_data,
    input  logic en,
    output logic gnt_fetch,
    output logic gnt_data
);

    logic ptr;

    always_comb begin
        gnt_data  = en && req_data  && (!req_fetch || (ptr == PORT_D));
        gnt_fetch = en && req_fetch && (!req_data  || (ptr == PORT_I));
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            ptr <= PORT_D;
        end else if (gnt_data) begin
            ptr <= PORT_I;
        end else if (gnt_fetch) begin
            ptr <= PORT_D;
        end
    end

endmodule

// File: rtl/mips32_mem_responder.sv
// Word-addressed memory slave serving the fetch and data ports with wait states,
// round-robin arbitration and out-of-range error reporting.
module mips32_mem_responder
    import mips32_mem_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int AW          = AW_DEF,
    parameter int WAIT_STATES = WAIT_STATES_DEF
) (
    input  logic        clk1,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        err,
    output logic        busy
);

    mem_state_t state, state_nxt;

    logic [3:0]    cnt;
    logic          port_q;
    logic          we_q;
    logic          bad_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rd_q;

    logic          gnt_fetch, gnt_data, grant, idle;
    logic [31:0]   sel_addr;
    logic [AW-1:0] rd_idx;
    logic          rd_bad;
    logic          load_rd;

    logic [31:0]   mem [DEPTH];

    assign idle = (state == IDLE);

    mips32_rr_arbiter u_arb (
        .clk1      (clk1),
        .reset     (reset),
        .req_fetch (i_req),
        .req_data  (d_req),
        .en        (idle),
        .gnt_fetch (gnt_fetch),
        .gnt_data  (gnt_data)
    );

    assign grant    = gnt_fetch | gnt_data;
    assign sel_addr = gnt_data ? d_addr : i_addr;

    // With zero wait states the array is read straight off the granted request.
    always_comb begin
        rd_idx = idle ? sel_addr[AW-1:0] : idx_q;
        rd_bad = idle ? (|sel_addr[31:AW]) : bad_q;
    end

    always_comb begin
        state_nxt = state;
        load_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
                    load_rd   = (WAIT_STATES == 0);
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                    load_rd   = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            port_q <= PORT_D;
            we_q   <= 1'b0;
            bad_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                cnt    <= 4'(WAIT_STATES);
                port_q <= gnt_data ? PORT_D : PORT_I;
                we_q   <= gnt_data && d_we;
                bad_q  <= |sel_addr[31:AW];
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Stores commit as RESP ends; a reset beforehand forces IDLE and drops them.
    always_ff @(posedge clk1) begin
        if (grant) begin
            idx_q   <= sel_addr[AW-1:0];
            wdata_q <= d_wdata;
        end
        if (load_rd) begin
            rd_q <= rd_bad ? '0 : mem[rd_idx];
        end
        if ((state == RESP) && we_q && !bad_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    always_comb begin
        i_ack   = (state == RESP) && (port_q == PORT_I);
        d_ack   = (state == RESP) && (port_q == PORT_D);
        err     = (state == RESP) && bad_q;
        busy    = !idle;
        i_rdata = i_ack ? rd_q : '0;
        d_rdata = (d_ack && !we_q) ? rd_q : '0;
    end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Self-checking bench: three responders (1, 0 and 3 wait states) share one stimulus bus.
module tb_mips32_mem_responder;
    import mips32_mem_pkg::*;

    logic        clk1 = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;

    logic [31:0] o_i_rdata [3];
    logic [31:0] o_d_rdata [3];
    logic        o_i_ack   [3];
    logic        o_d_ack   [3];
    logic        o_err     [3];
    logic        o_busy    [3];

    int sel = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];

    always #5 clk1 = ~clk1;

    mips32_mem_responder #(.DEPTH(1024), .AW(10), .WAIT_STATES(1)) u_ws1 (
        .clk1(clk1), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(o_i_rdata[0]), .i_ack(o_i_ack[0]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(o_d_rdata[0]), .d_ack(o_d_ack[0]), .err(o_err[0]), .busy(o_busy[0])
    );

    mips32_mem_responder #(.DEPTH(1024), .AW(10), .WAIT_STATES(0)) u_ws0 (
        .clk1(clk1), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(o_i_rdata[1]), .i_ack(o_i_ack[1]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(o_d_rdata[1]), .d_ack(o_d_ack[1]), .err(o_err[1]), .busy(o_busy[1])
    );

    mips32_mem_responder #(.DEPTH(1024), .AW(10), .WAIT_STATES(3)) u_ws3 (
        .clk1(clk1), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(o_i_rdata[2]), .i_ack(o_i_ack[2]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(o_d_rdata[2]), .d_ack(o_d_ack[2]), .err(o_err[2]), .busy(o_busy[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, " i_ack"},   32'(o_i_ack[sel]), 0);
        chk({name, " d_ack"},   32'(o_d_ack[sel]), 0);
        chk({name, " err"},     32'(o_err[sel]),   0);
        chk({name, " busy"},    32'(o_busy[sel]),  0);
        chk({name, " i_rdata"}, o_i_rdata[sel],    0);
        chk({name, " d_rdata"}, o_d_rdata[sel],    0);
    endtask

    task automatic expect_resp(input logic port, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.port  = port;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic drive(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        if (port == PORT_I) begin
            i_req  = 1'b1;
            i_addr = addr;
        end else begin
            d_req   = 1'b1;
            d_we    = we;
            d_addr  = addr;
            d_wdata = wdata;
        end
    endtask

    // Waits (bounded) for an ack on the selected instance and scores it against the queue head.
    task automatic collect(input string name, output int waited);
        logic got;
        exp_t e;
        got = 1'b0;
        waited = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk1);
            if (o_i_ack[sel] || o_d_ack[sel]) begin
                got = 1'b1;
                waited = k;
            end
        end
        chk({name, " ack seen"}, 32'(got), 1);
        if (got) begin
            chk({name, " ack expected"}, 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({name, " port"}, 32'(o_d_ack[sel]), 32'(e.port));
                chk({name, " single ack"}, 32'(o_i_ack[sel] & o_d_ack[sel]), 0);
                chk({name, " rdata"}, o_d_ack[sel] ? o_d_rdata[sel] : o_i_rdata[sel], e.rdata);
                chk({name, " err"}, 32'(o_err[sel]), 32'(e.err));
            end
        end
    endtask

    task automatic xact(input string name, input logic port, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic err);
        int w;
        expect_resp(port, rdata, err);
        drive(port, we, addr, wdata);
        collect(name, w);
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk1);
        reset = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk1);
        reset = 1'b0;
    endtask

    initial begin
        int w;
        int acks;

        vecs[0]  = '{PORT_D, 1'b1, 32'd5,         32'h2801000A, 32'h0,        1'b0};
        vecs[1]  = '{PORT_I, 1'b0, 32'd5,         32'h0,        32'h2801000A, 1'b0};
        vecs[2]  = '{PORT_D, 1'b1, 32'd20,        32'hDEADBEEF, 32'h0,        1'b0};
        vecs[3]  = '{PORT_D, 1'b0, 32'd20,        32'h0,        32'hDEADBEEF, 1'b0};
        vecs[4]  = '{PORT_D, 1'b1, 32'd0,         32'hA5A50000, 32'h0,        1'b0};
        vecs[5]  = '{PORT_D, 1'b1, 32'h00000400,  32'h1,        32'h0,        1'b1};
        vecs[6]  = '{PORT_D, 1'b0, 32'h00000400,  32'h0,        32'h0,        1'b1};
        vecs[7]  = '{PORT_D, 1'b0, 32'd0,         32'h0,        32'hA5A50000, 1'b0};
        vecs[8]  = '{PORT_D, 1'b1, 32'h3FF,       32'h12345678, 32'h0,        1'b0};
        vecs[9]  = '{PORT_D, 1'b0, 32'h3FF,       32'h0,        32'h12345678, 1'b0};
        vecs[10] = '{PORT_I, 1'b0, 32'h3FF,       32'h0,        32'h12345678, 1'b0};
        vecs[11] = '{PORT_D, 1'b0, 32'h80000000,  32'h0,        32'h0,        1'b1};
        vecs[12] = '{PORT_I, 1'b0, 32'h00000400,  32'h0,        32'h0,        1'b1};
        vecs[13] = '{PORT_D, 1'b1, 32'd21,        32'hCAFEF00D, 32'h0,        1'b0};
        vecs[14] = '{PORT_D, 1'b0, 32'd20,        32'h0,        32'hDEADBEEF, 1'b0};
        vecs[15] = '{PORT_D, 1'b0, 32'd21,        32'h0,        32'hCAFEF00D, 1'b0};

        // Reset state on the one-wait-state instance.
        sel = 0;
        @(negedge clk1);
        @(negedge clk1);
        chk_idle_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            xact($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
                 vecs[i].wdata, vecs[i].rdata, vecs[i].err);
        end

        // Cycle-exact single fetch: ack only in cycle 2, busy in cycles 1-2.
        @(negedge clk1);
        drive(PORT_I, 1'b0, 32'd5, 32'h0);
        @(negedge clk1);
        chk("fetch c1 busy", 32'(o_busy[0]), 1);
        chk("fetch c1 i_ack", 32'(o_i_ack[0]), 0);
        chk("fetch c1 i_rdata", o_i_rdata[0], 0);
        @(negedge clk1);
        chk("fetch c2 busy", 32'(o_busy[0]), 1);
        chk("fetch c2 i_ack", 32'(o_i_ack[0]), 1);
        chk("fetch c2 i_rdata", o_i_rdata[0], 32'h2801000A);
        chk("fetch c2 d_ack", 32'(o_d_ack[0]), 0);
        i_req = 1'b0;
        @(negedge clk1);
        chk_idle_outputs("fetch c3");

        // Both ports held from reset: data first, then strict alternation every 3 cycles.
        do_reset();
        expect_resp(PORT_D, 32'hDEADBEEF, 1'b0);
        expect_resp(PORT_I, 32'h2801000A, 1'b0);
        expect_resp(PORT_D, 32'hDEADBEEF, 1'b0);
        expect_resp(PORT_I, 32'h2801000A, 1'b0);
        drive(PORT_D, 1'b0, 32'd20, 32'h0);
        drive(PORT_I, 1'b0, 32'd5, 32'h0);
        for (int j = 0; j < 4; j++) begin
            collect($sformatf("conflict%0d", j), w);
            if (j > 0) chk($sformatf("conflict%0d spacing", j), w, 3);
        end
        i_req = 1'b0;
        d_req = 1'b0;

        // Zero wait states: back-to-back fetches ack in cycles 1 and 3.
        do_reset();
        sel = 1;
        xact("ws0 store0", PORT_D, 1'b1, 32'd0, 32'h00001111, 32'h0, 1'b0);
        xact("ws0 store1", PORT_D, 1'b1, 32'd1, 32'h00002222, 32'h0, 1'b0);
        @(negedge clk1);
        drive(PORT_I, 1'b0, 32'd0, 32'h0);
        @(negedge clk1);
        chk("ws0 c1 i_ack", 32'(o_i_ack[1]), 1);
        chk("ws0 c1 i_rdata", o_i_rdata[1], 32'h00001111);
        i_addr = 32'd1;
        @(negedge clk1);
        chk("ws0 c2 i_ack", 32'(o_i_ack[1]), 0);
        chk("ws0 c2 busy", 32'(o_busy[1]), 0);
        @(negedge clk1);
        chk("ws0 c3 i_ack", 32'(o_i_ack[1]), 1);
        chk("ws0 c3 i_rdata", o_i_rdata[1], 32'h00002222);
        i_req = 1'b0;
        @(negedge clk1);
        chk_idle_outputs("ws0 c4");

        // Three wait states: reset during WAIT of a store kills it without an ack.
        do_reset();
        sel = 2;
        xact("ws3 preload", PORT_D, 1'b1, 32'd7, 32'h11110007, 32'h0, 1'b0);
        @(negedge clk1);
        drive(PORT_D, 1'b1, 32'd7, 32'h77777777);
        @(negedge clk1);
        @(negedge clk1);
        chk("ws3 busy in wait", 32'(o_busy[2]), 1);
        #2;
        reset = 1'b1;
        d_req = 1'b0;
        #1;
        chk_idle_outputs("ws3 async reset");
        @(negedge clk1);
        reset = 1'b0;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk1);
            if (o_i_ack[2] || o_d_ack[2]) acks++;
        end
        chk("ws3 no ack after reset", acks, 0);
        xact("ws3 reload", PORT_D, 1'b0, 32'd7, 32'h0, 32'h11110007, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
